// File: rtl/syn_mem_sequencer.sv
// Data-memory master for one Synapse column: runs LOAD (stream block write)
// and MAC (strided read sweep, pipeline drain, result writeback) commands.
module syn_mem_sequencer #(
  parameter int AddrDMEM  = 8,
  parameter int DataWidth = 16,
  parameter int LenWidth  = 8,
  parameter int PipeLat   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_op,
  input  logic [AddrDMEM-1:0]  cmd_base_r,
  input  logic [AddrDMEM-1:0]  cmd_base_w,
  input  logic [AddrDMEM-1:0]  cmd_stride,
  input  logic [LenWidth-1:0]  cmd_len,
  input  logic                 s_valid,
  input  logic [DataWidth-1:0] s_data,
  output logic                 s_ready,
  input  logic                 stall,
  output logic [AddrDMEM-1:0]  r_addr,
  output logic [AddrDMEM-1:0]  w_addr,
  output logic                 we_ram,
  output logic [DataWidth-1:0] ram_wdata,
  output logic                 sel_wsrc,
  output logic                 rd_vld,
  output logic                 acc_clr,
  output logic                 busy,
  output logic                 done
);

  localparam int DrW = $clog2(PipeLat + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_WB, S_DONE} state_t;

  state_t               state_reg, state_next;
  logic [LenWidth-1:0]  cnt_reg, cnt_next;
  logic [LenWidth-1:0]  len_reg, len_next;
  logic [AddrDMEM-1:0]  base_w_reg, base_w_next;
  logic [AddrDMEM-1:0]  stride_reg, stride_next;
  logic [AddrDMEM-1:0]  ptr_reg, ptr_next;
  logic [DrW-1:0]       drain_reg, drain_next;
  logic [AddrDMEM-1:0]  r_addr_reg, r_addr_next;
  logic [AddrDMEM-1:0]  w_addr_reg, w_addr_next;
  logic [DataWidth-1:0] wdata_reg, wdata_next;
  logic                 we_reg, we_next;
  logic                 sel_reg, sel_next;
  logic                 rd_vld_reg, rd_vld_next;
  logic                 acc_clr_reg, acc_clr_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 last_item;

  // done is registered and lags DONE by one cycle, so hold off acceptance
  // until the pulse has been seen.
  assign cmd_ready = (state_reg == S_IDLE) && !done_reg;
  assign s_ready   = (state_reg == S_LOAD);
  assign last_item = (cnt_reg == len_reg - LenWidth'(1));

  assign r_addr    = r_addr_reg;
  assign w_addr    = w_addr_reg;
  assign we_ram    = we_reg;
  assign ram_wdata = wdata_reg;
  assign sel_wsrc  = sel_reg;
  assign rd_vld    = rd_vld_reg;
  assign acc_clr   = acc_clr_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    len_next     = len_reg;
    base_w_next  = base_w_reg;
    stride_next  = stride_reg;
    ptr_next     = ptr_reg;
    drain_next   = drain_reg;
    r_addr_next  = r_addr_reg;
    w_addr_next  = w_addr_reg;
    wdata_next   = wdata_reg;
    sel_next     = sel_reg;
    we_next      = 1'b0;
    rd_vld_next  = 1'b0;
    acc_clr_next = 1'b0;
    done_next    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          len_next    = cmd_len;
          base_w_next = cmd_base_w;
          stride_next = cmd_stride;
          ptr_next    = cmd_base_r;
          cnt_next    = '0;
          if (cmd_len == '0) state_next = S_DONE;
          else               state_next = cmd_op ? S_RUN : S_LOAD;
        end
      end
      S_LOAD: begin
        if (s_valid) begin
          we_next     = 1'b1;
          w_addr_next = base_w_reg + AddrDMEM'(cnt_reg);
          wdata_next  = s_data;
          sel_next    = 1'b0;
          cnt_next    = cnt_reg + LenWidth'(1);
          if (last_item) state_next = S_DONE;
        end
      end
      S_RUN: begin
        // ptr_reg tracks base_r + i*stride incrementally; carries drop off.
        if (!stall) begin
          r_addr_next  = ptr_reg;
          ptr_next     = ptr_reg + stride_reg;
          rd_vld_next  = 1'b1;
          acc_clr_next = (cnt_reg == '0);
          cnt_next     = cnt_reg + LenWidth'(1);
          if (last_item) begin
            state_next = S_DRAIN;
            drain_next = DrW'(PipeLat);
          end
        end
      end
      S_DRAIN: begin
        if (drain_reg <= DrW'(1)) state_next = S_WB;
        else                      drain_next = drain_reg - DrW'(1);
      end
      S_WB: begin
        we_next     = 1'b1;
        w_addr_next = base_w_reg;
        sel_next    = 1'b1;
        state_next  = S_DONE;
      end
      S_DONE: begin
        done_next  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    busy_next = (state_next != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      len_reg     <= '0;
      base_w_reg  <= '0;
      stride_reg  <= '0;
      ptr_reg     <= '0;
      drain_reg   <= '0;
      r_addr_reg  <= '0;
      w_addr_reg  <= '0;
      wdata_reg   <= '0;
      we_reg      <= 1'b0;
      sel_reg     <= 1'b0;
      rd_vld_reg  <= 1'b0;
      acc_clr_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      len_reg     <= len_next;
      base_w_reg  <= base_w_next;
      stride_reg  <= stride_next;
      ptr_reg     <= ptr_next;
      drain_reg   <= drain_next;
      r_addr_reg  <= r_addr_next;
      w_addr_reg  <= w_addr_next;
      wdata_reg   <= wdata_next;
      we_reg      <= we_next;
      sel_reg     <= sel_next;
      rd_vld_reg  <= rd_vld_next;
      acc_clr_reg <= acc_clr_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

endmodule

// File: tb/tb_syn_mem_sequencer.sv
// Directed bench for syn_mem_sequencer: LOAD, MAC (plain, stalled, wrapped),
// zero-length commands and mid-command reset.
module tb_syn_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [7:0]  cmd_base_r, cmd_base_w, cmd_stride, cmd_len;
  logic        s_valid, s_ready;
  logic [15:0] s_data;
  logic        stall;
  logic [7:0]  r_addr, w_addr;
  logic        we_ram, sel_wsrc, rd_vld, acc_clr, busy, done;
  logic [15:0] ram_wdata;

  int total = 0;
  int bad   = 0;

  syn_mem_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base_r(cmd_base_r), .cmd_base_w(cmd_base_w), .cmd_stride(cmd_stride),
    .cmd_len(cmd_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .stall(stall),
    .r_addr(r_addr), .w_addr(w_addr), .we_ram(we_ram), .ram_wdata(ram_wdata),
    .sel_wsrc(sel_wsrc), .rd_vld(rd_vld), .acc_clr(acc_clr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, ".s_ready"},   32'(s_ready),   32'd0);
    chk({tag, ".r_addr"},    32'(r_addr),    32'd0);
    chk({tag, ".w_addr"},    32'(w_addr),    32'd0);
    chk({tag, ".we_ram"},    32'(we_ram),    32'd0);
    chk({tag, ".wdata"},     32'(ram_wdata), 32'd0);
    chk({tag, ".sel_wsrc"},  32'(sel_wsrc),  32'd0);
    chk({tag, ".rd_vld"},    32'(rd_vld),    32'd0);
    chk({tag, ".acc_clr"},   32'(acc_clr),   32'd0);
    chk({tag, ".busy"},      32'(busy),      32'd0);
    chk({tag, ".done"},      32'(done),      32'd0);
  endtask

  task automatic issue_cmd(input logic op, input logic [7:0] br, input logic [7:0] bw,
                           input logic [7:0] st, input logic [7:0] ln);
    cmd_valid = 1'b1; cmd_op = op; cmd_base_r = br; cmd_base_w = bw;
    cmd_stride = st; cmd_len = ln;
    tick();
    cmd_valid = 1'b0;
  endtask

  // len=3 MAC sweep with hand-supplied read addresses and an optional stall
  // window (counted in RUN cycles from the first issue cycle).
  task automatic run_mac(input string tag, input logic [7:0] br, input logic [7:0] st,
                         input logic [7:0] bw, input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2, input int st_at, input int st_n);
    logic [7:0] exp_a [3];
    logic [7:0] prev;
    int i;
    int cyc;
    exp_a[0] = a0; exp_a[1] = a1; exp_a[2] = a2;
    issue_cmd(1'b1, br, bw, st, 8'd3);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    i = 0; cyc = 0; prev = r_addr;
    while (i < 3 && cyc < 20) begin
      stall = (cyc >= st_at) && (cyc < st_at + st_n);
      tick();
      if (stall) begin
        chk($sformatf("%s.stall_vld%0d", tag, cyc), 32'(rd_vld), 32'd0);
        chk($sformatf("%s.stall_hold%0d", tag, cyc), 32'(r_addr), 32'(prev));
      end else begin
        chk($sformatf("%s.rd_vld%0d", tag, i), 32'(rd_vld), 32'd1);
        chk($sformatf("%s.r_addr%0d", tag, i), 32'(r_addr), 32'(exp_a[i]));
        chk($sformatf("%s.acc_clr%0d", tag, i), 32'(acc_clr), (i == 0) ? 32'd1 : 32'd0);
        prev = r_addr;
        i++;
      end
      cyc++;
    end
    stall = 1'b0;
    chk({tag, ".issued"}, 32'(i), 32'd3);
    // Stray command during drain must be ignored.
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base_w = 8'h77; cmd_len = 8'd5;
    for (int d = 0; d < 2; d++) begin
      stall = 1'b1;
      tick();
      chk($sformatf("%s.drain_vld%0d", tag, d), 32'(rd_vld), 32'd0);
      chk($sformatf("%s.drain_we%0d", tag, d), 32'(we_ram), 32'd0);
      chk($sformatf("%s.drain_raddr%0d", tag, d), 32'(r_addr), 32'(a2));
    end
    stall = 1'b0;
    cmd_valid = 1'b0;
    tick();
    chk({tag, ".wb_we"},    32'(we_ram),   32'd1);
    chk({tag, ".wb_sel"},   32'(sel_wsrc), 32'd1);
    chk({tag, ".wb_waddr"}, 32'(w_addr),   32'(bw));
    chk({tag, ".wb_done"},  32'(done),     32'd0);
    tick();
    chk({tag, ".done"},     32'(done),     32'd1);
    chk({tag, ".done_we"},  32'(we_ram),   32'd0);
    chk({tag, ".done_rdy"}, 32'(cmd_ready), 32'd0);
    tick();
    chk({tag, ".post_done"}, 32'(done),     32'd0);
    chk({tag, ".post_busy"}, 32'(busy),     32'd0);
    chk({tag, ".post_rdy"},  32'(cmd_ready), 32'd1);
    chk({tag, ".post_sr"},   32'(s_ready),  32'd0);
    $display("MAC %s base_r=%02h stride=%0d base_w=%02h stall_at=%0d n=%0d checked",
             tag, br, st, bw, st_at, st_n);
  endtask

  initial begin
    int writes;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base_r = '0; cmd_base_w = '0;
    cmd_stride = '0; cmd_len = '0; s_valid = 1'b0; s_data = '0; stall = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_reset_outs("reset");
    $display("RESET checked");

    // LOAD with a gapped stream
    issue_cmd(1'b0, 8'h00, 8'h10, 8'h00, 8'd4);
    chk("load.s_ready", 32'(s_ready), 32'd1);
    chk("load.busy",    32'(busy),    32'd1);
    chk("load.cmd_rdy", 32'(cmd_ready), 32'd0);
    writes = 0;
    for (int k = 0; k < 8; k++) begin
      s_valid = (k % 2 == 0);
      s_data  = 16'hA1 + 16'(k / 2);
      tick();
      chk($sformatf("load.we%0d", k), 32'(we_ram), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("load.done%0d", k), 32'(done), (k == 7) ? 32'd1 : 32'd0);
      if (we_ram) writes++;
      if (k % 2 == 0) begin
        chk($sformatf("load.waddr%0d", k), 32'(w_addr), 32'h10 + 32'(k / 2));
        chk($sformatf("load.wdata%0d", k), 32'(ram_wdata), 32'hA1 + 32'(k / 2));
        chk($sformatf("load.sel%0d", k), 32'(sel_wsrc), 32'd0);
      end
    end
    s_valid = 1'b0;
    chk("load.writes", 32'(writes), 32'd4);
    tick();
    chk("load.post_done", 32'(done), 32'd0);
    chk("load.post_busy", 32'(busy), 32'd0);
    chk("load.post_rdy",  32'(cmd_ready), 32'd1);
    $display("LOAD base_w=10 len=4 checked");

    run_mac("mac",   8'h20, 8'd2, 8'h05, 8'h20, 8'h22, 8'h24, 99, 0);
    run_mac("stall", 8'h20, 8'd2, 8'h06, 8'h20, 8'h22, 8'h24, 1, 2);
    run_mac("wrap",  8'hFE, 8'd3, 8'h07, 8'hFE, 8'h01, 8'h04, 99, 0);

    // Zero-length commands for both ops
    for (int op = 0; op < 2; op++) begin
      issue_cmd(op[0], 8'h40, 8'h50, 8'd1, 8'd0);
      chk($sformatf("len0_%0d.c1_done", op), 32'(done), 32'd0);
      chk($sformatf("len0_%0d.c1_busy", op), 32'(busy), 32'd1);
      chk($sformatf("len0_%0d.c1_sr", op),   32'(s_ready), 32'd0);
      tick();
      chk($sformatf("len0_%0d.c2_done", op), 32'(done), 32'd1);
      chk($sformatf("len0_%0d.c2_vld", op),  32'(rd_vld | we_ram), 32'd0);
      tick();
      chk($sformatf("len0_%0d.c3_done", op), 32'(done), 32'd0);
      chk($sformatf("len0_%0d.c3_rdy", op),  32'(cmd_ready), 32'd1);
      $display("LEN0 op=%0d checked", op);
    end

    // Reset during the second LOAD handshake
    issue_cmd(1'b0, 8'h00, 8'h40, 8'h00, 8'd4);
    s_valid = 1'b1; s_data = 16'h0055;
    tick();
    chk("rst.first_we",    32'(we_ram), 32'd1);
    chk("rst.first_waddr", 32'(w_addr), 32'h40);
    s_data = 16'h0066; rst = 1'b1;
    tick();
    rst = 1'b0; s_valid = 1'b1;
    chk_reset_outs("rst");
    tick();
    s_valid = 1'b0;
    chk("rst.no_we",   32'(we_ram),    32'd0);
    chk("rst.cmd_rdy", 32'(cmd_ready), 32'd1);
    chk("rst.idle_sr", 32'(s_ready),   32'd0);
    issue_cmd(1'b0, 8'h00, 8'h30, 8'h00, 8'd1);
    s_valid = 1'b1; s_data = 16'h0099;
    tick();
    s_valid = 1'b0;
    chk("rst.new_we",    32'(we_ram),    32'd1);
    chk("rst.new_waddr", 32'(w_addr),    32'h30);
    chk("rst.new_wdata", 32'(ram_wdata), 32'h99);
    tick();
    chk("rst.new_done",  32'(done), 32'd1);
    $display("RESET-ABORT then LOAD base_w=30 checked");

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/syn_mem_sequencer.md
Name: syn_mem_sequencer

Overview:
Master-side controller for a Synapse data memory. It drives the memory's read address, write address and write enable, which the Synapse itself only consumes. It runs two kinds of command:
- LOAD: streams a block of words into data memory.
- MAC: sweeps a strided read sequence through the multiply/accumulate path, then writes the accumulated result back.

One sequencer sits beside each Synapse column and takes commands from the array-level scheduler.

Parameters:
- AddrDMEM, 8: data memory address width; addresses wrap modulo 2**AddrDMEM.
- DataWidth, 16: stream data width.
- LenWidth, 8: command length field width.
- PipeLat, 2: cycles from the last read address to the accumulated result being valid at the adder output (read, m_REG, add).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  1  0 = LOAD, 1 = MAC
- cmd_base_r  in  AddrDMEM  MAC read base address
- cmd_base_w  in  AddrDMEM  LOAD start address / MAC result address
- cmd_stride  in  AddrDMEM  MAC read stride
- cmd_len  in  LenWidth  word count
- s_valid  in  1  LOAD stream word valid
- s_data  in  DataWidth  LOAD stream word
- s_ready  out  1  LOAD stream accept
- stall  in  1  freezes MAC read issue
- r_addr  out  AddrDMEM  data memory read address
- w_addr  out  AddrDMEM  data memory write address
- we_ram  out  1  data memory write enable
- ram_wdata  out  DataWidth  write data for LOAD
- sel_wsrc  out  1  0 = stream data, 1 = adder output
- rd_vld  out  1  r_addr carries a live read this cycle
- acc_clr  out  1  first read of a MAC sweep (operand register cleared)
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse at command completion

Interface rules:
- Single clock clk.
- rst is synchronous, active-high.
- All outputs except cmd_ready and s_ready are registered.

Behaviour:
- Reset values: cmd_ready=1, s_ready=0, r_addr=0, w_addr=0, we_ram=0, ram_wdata=0, sel_wsrc=0, rd_vld=0, acc_clr=0, busy=0, done=0.
- Reset asserted mid-command aborts the command. No further writes occur and the state returns to IDLE.
- States: IDLE, LOAD, RUN, DRAIN, WB, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch all command fields and clear count i=0.
  - len==0 goes straight to DONE with no memory access.
  - Otherwise op=0 goes to LOAD, op=1 goes to RUN.
- LOAD:
  - s_ready=1 combinationally.
  - Each s_valid&&s_ready: next cycle we_ram=1, w_addr=base_w+i (mod 2**AddrDMEM), ram_wdata=s_data, sel_wsrc=0; then i++.
  - Cycles without a handshake drive we_ram=0 next cycle.
  - After the len-th handshake go to DONE. The final write and the DONE entry happen in the same cycle.
- RUN:
  - Each cycle with stall=0: next cycle r_addr=base_r+i*stride (mod 2**AddrDMEM), rd_vld=1, acc_clr=(i==0); then i++.
  - stall=1: rd_vld=0 next cycle, r_addr holds, i holds.
  - After the len-th issue go to DRAIN with a counter set to PipeLat.
- DRAIN:
  - Counts PipeLat cycles with rd_vld=0; stall is ignored.
  - Then go to WB.
- WB:
  - One cycle: we_ram=1, w_addr=base_w, sel_wsrc=1.
  - Then go to DONE.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - cmd_ready is 0 here; a new command is accepted the cycle after done.
- busy=1 in every state other than IDLE.
- r_addr is never modified outside RUN.
- we_ram is asserted only in LOAD write cycles and in WB.
- Address arithmetic is unsigned with the carry discarded, so wrap-around is legal. Example: base 0xFE, stride 3 gives 0xFE, 0x01, 0x04.
- cmd_valid outside IDLE is ignored and the command is not latched.
- s_valid outside LOAD is ignored and s_ready=0.

Test Plan:
- LOAD, base_w=0x10, len=4, s_data 0xA1..0xA4 with s_valid gapped every other cycle -> exactly four we_ram pulses at w_addr 0x10..0x13 with matching data, then done one cycle after the last write, busy then drops.
- MAC, base_r=0x20, stride=2, len=3 -> r_addr 0x20, 0x22, 0x24 with rd_vld on 3 consecutive cycles and acc_clr only on the first; 2 idle cycles; we_ram=1, sel_wsrc=1, w_addr=base_w; done on the following cycle.
- MAC with stall=1 on the second issue cycle for 2 cycles -> sequence 0x20, hold (rd_vld=0) x2, 0x22, 0x24; writeback is delayed by 2 cycles.
- Wrap: MAC base_r=0xFE, stride=3, len=3 -> r_addr 0xFE, 0x01, 0x04.
- len=0 for both ops -> no rd_vld and no we_ram; done pulses exactly 2 cycles after the command is accepted.
- rst asserted during the second LOAD handshake -> all outputs equal reset values next cycle, no further writes, cmd_ready=1; a new command is accepted normally afterwards.
